c2h_readback_packer: RTL and testbench



---
 rtl/c2h_readback_packer_pkg.sv | 16 +
 rtl/c2h_readback_packer.sv | 189 ++++++++++++++++++
 tb/tb_c2h_readback_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c2h_readback_packer_pkg.sv
// Shared constants and state encoding for the C2H readback packer.
package c2h_readback_packer_pkg;

   localparam int C2H_AXIS_W = 256;                    // C2H stream width
   localparam int C2H_WORD_W = 32;                     // ICAP word width
   localparam int C2H_LEN_W  = 16;                     // transfer length field width
   localparam int C2H_WPB    = C2H_AXIS_W / C2H_WORD_W; // words per beat
   localparam int C2H_KEEP_W = C2H_AXIS_W / 8;         // tkeep width

   typedef enum logic [1:0] {
      C2H_IDLE    = 2'd0,
      C2H_COLLECT = 2'd1,
      C2H_SEND    = 2'd2
   } c2h_state_t;

endpackage

// File: rtl/c2h_readback_packer.sv
// Packs 32-bit configuration readback words into 256-bit C2H AXI-Stream
// beats and frames each transfer with tlast. Words are collected into a
// pack register, then the beat is presented and held until accepted.
module c2h_readback_packer
   import c2h_readback_packer_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH = C2H_AXIS_W,
   parameter int WORD_WIDTH      = C2H_WORD_W,
   parameter int LEN_WIDTH       = C2H_LEN_W
) (
   input  logic                         sys_clk,
   input  logic                         sys_resetn,
   input  logic                         start,
   input  logic [LEN_WIDTH-1:0]         length,
   input  logic                         abort,
   input  logic                         s_word_tvalid,
   output logic                         s_word_tready,
   input  logic [WORD_WIDTH-1:0]        s_word_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                         m_axis_tlast,
   output logic                         busy,
   output logic                         done,
   output logic                         err_start_busy
);

   localparam int WPB    = AXIS_DATA_WIDTH / WORD_WIDTH;
   localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
   localparam int BPW    = WORD_WIDTH / 8;
   localparam int LANE_W = $clog2(WPB) + 1;

   c2h_state_t                 state_r, state_nxt_s;
   logic [AXIS_DATA_WIDTH-1:0] pack_r, pack_nxt_s, merged_s;
   logic [LANE_W-1:0]          lane_r, lane_nxt_s;
   logic [LEN_WIDTH-1:0]       remaining_r, remaining_nxt_s;
   logic                       tvalid_r, tvalid_nxt_s;
   logic [AXIS_DATA_WIDTH-1:0] tdata_r, tdata_nxt_s;
   logic [KEEP_W-1:0]          tkeep_r, tkeep_nxt_s, keep_s;
   logic                       tlast_r, tlast_nxt_s;
   logic                       tready_r, busy_r, done_r, err_r;
   logic                       done_nxt_s, err_nxt_s;
   logic                       word_hs_s;

   assign word_hs_s = s_word_tvalid & tready_r;

   // Pack register with the incoming word dropped into the current lane, and keep mask for lane_r+1 filled lanes.
   always_comb begin
      merged_s = pack_r;
      merged_s[int'(lane_r[LANE_W-2:0]) * WORD_WIDTH +: WORD_WIDTH] = s_word_tdata;
      keep_s = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         keep_s[i] = (i < (int'(lane_r) + 1) * BPW);
      end
   end

   // Next-state and datapath decisions; abort overrides everything.
   always_comb begin
      state_nxt_s     = state_r;
      pack_nxt_s      = pack_r;
      lane_nxt_s      = lane_r;
      remaining_nxt_s = remaining_r;
      tvalid_nxt_s    = tvalid_r;
      tdata_nxt_s     = tdata_r;
      tkeep_nxt_s     = tkeep_r;
      tlast_nxt_s     = tlast_r;
      done_nxt_s      = 1'b0;
      err_nxt_s       = 1'b0;
      if (abort) begin
         state_nxt_s     = C2H_IDLE;
         pack_nxt_s      = '0;
         lane_nxt_s      = '0;
         remaining_nxt_s = '0;
         tvalid_nxt_s    = 1'b0;
         tdata_nxt_s     = '0;
         tkeep_nxt_s     = '0;
         tlast_nxt_s     = 1'b0;
      end else begin
         case (state_r)
            C2H_IDLE: begin
               if (start) begin
                  if (length != '0) begin
                     state_nxt_s     = C2H_COLLECT;
                     remaining_nxt_s = length;
                     lane_nxt_s      = '0;
                     pack_nxt_s      = '0;
                  end else begin
                     done_nxt_s = 1'b1;
                  end
               end else begin
                  state_nxt_s = C2H_IDLE;
               end
            end
            C2H_COLLECT: begin
               err_nxt_s = start;
               if (word_hs_s) begin
                  pack_nxt_s      = merged_s;
                  lane_nxt_s      = lane_r + LANE_W'(1);
                  remaining_nxt_s = remaining_r - LEN_WIDTH'(1);
                  // The accepted word closes the beat when it fills the last lane or is the last word.
                  if ((lane_r == LANE_W'(WPB - 1)) || (remaining_r == LEN_WIDTH'(1))) begin
                     state_nxt_s  = C2H_SEND;
                     tvalid_nxt_s = 1'b1;
                     tdata_nxt_s  = merged_s;
                     tkeep_nxt_s  = keep_s;
                     tlast_nxt_s  = (remaining_r == LEN_WIDTH'(1));
                  end else begin
                     state_nxt_s = C2H_COLLECT;
                  end
               end else begin
                  state_nxt_s = C2H_COLLECT;
               end
            end
            C2H_SEND: begin
               err_nxt_s = start;
               if (m_axis_tready) begin
                  tvalid_nxt_s = 1'b0;
                  tdata_nxt_s  = '0;
                  tkeep_nxt_s  = '0;
                  tlast_nxt_s  = 1'b0;
                  lane_nxt_s   = '0;
                  pack_nxt_s   = '0;
                  if (tlast_r) begin
                     state_nxt_s = C2H_IDLE;
                     done_nxt_s  = 1'b1;
                  end else begin
                     state_nxt_s = C2H_COLLECT;
                  end
               end else begin
                  state_nxt_s = C2H_SEND;
               end
            end
            default: begin
               state_nxt_s  = C2H_IDLE;
               tvalid_nxt_s = 1'b0;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         state_r <= C2H_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_resetn) begin
      if (!sys_resetn) begin
         pack_r      <= '0;
         lane_r      <= '0;
         remaining_r <= '0;
         tvalid_r    <= 1'b0;
         tdata_r     <= '0;
         tkeep_r     <= '0;
         tlast_r     <= 1'b0;
         tready_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         pack_r      <= pack_nxt_s;
         lane_r      <= lane_nxt_s;
         remaining_r <= remaining_nxt_s;
         tvalid_r    <= tvalid_nxt_s;
         tdata_r     <= tdata_nxt_s;
         tkeep_r     <= tkeep_nxt_s;
         tlast_r     <= tlast_nxt_s;
         tready_r    <= (state_nxt_s == C2H_COLLECT);
         busy_r      <= (state_nxt_s != C2H_IDLE);
         done_r      <= done_nxt_s;
         err_r       <= err_nxt_s;
      end
   end

   assign s_word_tready  = tready_r;
   assign m_axis_tvalid  = tvalid_r;
   assign m_axis_tdata   = tdata_r;
   assign m_axis_tkeep   = tkeep_r;
   assign m_axis_tlast   = tlast_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign err_start_busy = err_r;

endmodule

// File: tb/tb_c2h_readback_packer.sv
// Randomized self-checking bench for c2h_readback_packer. Expected beats
// are derived from the word list by chunking it into groups of eight.
module tb_c2h_readback_packer;

   typedef struct packed {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
   } beat_t;

   logic         sys_clk = 1'b0;
   logic         sys_resetn = 1'b0;
   logic         start = 1'b0;
   logic [15:0]  length = 16'd0;
   logic         abort = 1'b0;
   logic         s_word_tvalid = 1'b0;
   logic         s_word_tready;
   logic [31:0]  s_word_tdata = 32'd0;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b0;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tkeep;
   logic         m_axis_tlast;
   logic         busy, done, err_start_busy;

   c2h_readback_packer dut (
      .sys_clk(sys_clk), .sys_resetn(sys_resetn), .start(start), .length(length),
      .abort(abort), .s_word_tvalid(s_word_tvalid), .s_word_tready(s_word_tready),
      .s_word_tdata(s_word_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .busy(busy),
      .done(done), .err_start_busy(err_start_busy)
   );

   always #5 sys_clk = ~sys_clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rdy_mode = 0;
   int stall_n = 0;
   int stall_cycles = 0;
   int done_cnt = 0, err_cnt = 0, done_cyc = 0, hs_cyc = 0;
   bit prev_stall = 1'b0;
   beat_t prev_beat;
   beat_t got_q[$];
   beat_t exp_q[$];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   always @(posedge sys_clk) cyc <= cyc + 1;

   // Output monitor: records beats and pulses, checks hold-while-stalled.
   always @(negedge sys_clk) begin
      if (!sys_resetn) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, prev_beat);
         end
         if (m_axis_tvalid) check("word_ready_off", s_word_tready, 0);
         if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
            hs_cyc = cyc;
         end
         if (m_axis_tvalid && !m_axis_tready) stall_cycles++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (err_start_busy) err_cnt++;
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_beat  = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      end
   end

   // Downstream ready generator: 0 always ready, 1 random, 2 stall each beat 5 cycles.
   initial begin
      forever begin
         @(posedge sys_clk); #1;
         case (rdy_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = 1'($urandom_range(0, 1));
            default: begin
               if (m_axis_tvalid && stall_n < 5) begin
                  m_axis_tready = 1'b0; stall_n++;
               end else begin
                  m_axis_tready = 1'b1;
                  if (!m_axis_tvalid) stall_n = 0;
               end
            end
         endcase
      end
   end

   task automatic clear_mon();
      got_q.delete();
      done_cnt = 0; err_cnt = 0; stall_cycles = 0;
   endtask

   // Reference: split the word list into 8-word beats, last beat partial.
   task automatic build_expected(input logic [31:0] w[$]);
      exp_q.delete();
      for (int b = 0; b < w.size(); b += 8) begin
         beat_t e;
         int n;
         n = (w.size() - b < 8) ? (w.size() - b) : 8;
         e.data = '0;
         for (int j = 0; j < n; j++) e.data[j*32 +: 32] = w[b+j];
         e.keep = 32'((64'd1 << (4 * n)) - 64'd1);
         e.last = (b + 8 >= w.size());
         exp_q.push_back(e);
      end
   endtask

   task automatic issue_start(input int len);
      start = 1'b1; length = 16'(len);
      @(posedge sys_clk); #1;
      start = 1'b0;
   endtask

   task automatic push_words(input logic [31:0] w[$]);
      int i = 0;
      int guard = 0;
      bit acc;
      while (i < w.size() && guard < 5000) begin
         s_word_tvalid = ($urandom_range(0, 3) != 0);
         s_word_tdata  = s_word_tvalid ? w[i] : $urandom;
         @(negedge sys_clk);
         acc = s_word_tvalid && s_word_tready;
         @(posedge sys_clk); #1;
         if (acc) i++;
         guard++;
      end
      s_word_tvalid = 1'b0;
      check("push_timeout", i, w.size());
   endtask

   task automatic wait_done();
      int k = 0;
      while (done_cnt == 0 && k < 2000) begin
         @(posedge sys_clk); k++;
      end
      repeat (3) @(posedge sys_clk);
      #1;
   endtask

   task automatic compare_xfer(input string tag);
      check({tag, "_beats"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check({tag, "_data"}, got_q[i].data, exp_q[i].data);
         check({tag, "_keep"}, got_q[i].keep, exp_q[i].keep);
         check({tag, "_last"}, got_q[i].last, exp_q[i].last);
      end
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_done_lat"}, done_cyc - hs_cyc, 1);
      check({tag, "_busy_end"}, busy, 0);
   endtask

   task automatic run_xfer(input string tag, input logic [31:0] w[$]);
      clear_mon();
      build_expected(w);
      issue_start(w.size());
      check({tag, "_busy_on"}, busy, 1);
      push_words(w);
      wait_done();
      compare_xfer(tag);
   endtask

   initial begin
      logic [31:0] w[$];
      logic [31:0] part[$];

      // Reset values
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_outputs", {m_axis_tvalid, s_word_tready, busy, done, err_start_busy, m_axis_tlast}, 6'd0);
      check("rst_tkeep", m_axis_tkeep, 0);
      check("rst_tdata", m_axis_tdata, 0);
      sys_resetn = 1'b1;
      @(posedge sys_clk); #1;

      // Full single beat
      rdy_mode = 0;
      w.delete();
      for (int i = 1; i <= 8; i++) w.push_back(32'(i));
      run_xfer("len8", w);

      // Two beats, partial tail
      w.delete();
      for (int i = 0; i < 11; i++) w.push_back(32'hA0 + 32'(i));
      run_xfer("len11", w);

      // Downstream stall on every beat
      rdy_mode = 2;
      w.delete();
      for (int i = 0; i < 16; i++) w.push_back($urandom);
      run_xfer("len16_stall", w);
      check("stall_cycles", stall_cycles, 10);
      rdy_mode = 0;

      // Zero-length transfer
      clear_mon();
      issue_start(0);
      check("len0_done", done, 1);
      check("len0_busy", busy, 0);
      @(posedge sys_clk); #1;
      check("len0_done_off", done, 0);
      repeat (5) @(posedge sys_clk);
      #1;
      check("len0_beats", got_q.size(), 0);
      check("len0_done_cnt", done_cnt, 1);

      // Start while busy is ignored and flagged
      clear_mon();
      w.delete();
      for (int i = 0; i < 20; i++) w.push_back($urandom);
      build_expected(w);
      issue_start(20);
      fork
         push_words(w);
         begin
            repeat (5) @(posedge sys_clk);
            #1; start = 1'b1; length = 16'd4;
            @(posedge sys_clk); #1; start = 1'b0;
         end
      join
      wait_done();
      compare_xfer("busy_start");
      check("err_pulses", err_cnt, 1);

      // Abort mid-collect, then a fresh short transfer
      clear_mon();
      part.delete();
      for (int i = 0; i < 5; i++) part.push_back($urandom);
      issue_start(8);
      push_words(part);
      abort = 1'b1;
      @(posedge sys_clk); #1;
      abort = 1'b0;
      check("abort_idle", {busy, s_word_tready, m_axis_tvalid}, 3'd0);
      repeat (6) @(posedge sys_clk);
      #1;
      check("abort_beats", got_q.size(), 0);
      check("abort_done", done_cnt, 0);
      w.delete();
      w.push_back(32'hB0); w.push_back(32'hB1);
      run_xfer("post_abort", w);

      // Abort and start together: abort wins
      start = 1'b1; abort = 1'b1; length = 16'd3;
      @(posedge sys_clk); #1;
      start = 1'b0; abort = 1'b0;
      check("abort_start_busy", busy, 0);
      check("abort_start_err", err_start_busy, 0);

      // Asynchronous reset mid-transfer
      clear_mon();
      part.delete();
      for (int i = 0; i < 3; i++) part.push_back($urandom);
      issue_start(16);
      push_words(part);
      #2 sys_resetn = 1'b0;
      #1;
      check("arst_clear", {busy, s_word_tready, m_axis_tvalid}, 3'd0);
      @(posedge sys_clk); #1;
      sys_resetn = 1'b1;
      @(posedge sys_clk); #1;
      w.delete();
      for (int i = 0; i < 3; i++) w.push_back($urandom);
      run_xfer("post_arst", w);

      // Random transfers with random backpressure
      rdy_mode = 1;
      for (int t = 0; t < 12; t++) begin
         int len;
         len = (t == 11) ? 300 : $urandom_range(1, 40);
         w.delete();
         for (int i = 0; i < len; i++) w.push_back($urandom);
         run_xfer("rand", w);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
